// File: rtl/iq_pkg.sv
// iq_pkg: types and helpers shared by the I/Q deframer and the phase chain.
//   IQ_W          default sample width
//   pair_state_t  I/Q pairing FSM states
//   sat_w         clamp a signed value to the range of a w-bit signed word
package iq_pkg;

    localparam int IQ_W = 12;

    typedef enum logic [0:0] {
        WAIT_I = 1'b0,
        GOT_I  = 1'b1
    } pair_state_t;

    // Clamp x to [-2^(w-1), 2^(w-1)-1]; valid for 2 <= w <= 31.
    function automatic logic signed [31:0] sat_w(input logic signed [31:0] x,
                                                 input int                 w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            sat_w = hi;
        end else if (x < lo) begin
            sat_w = lo;
        end else begin
            sat_w = x;
        end
    endfunction

endpackage

// File: rtl/iq_deframer_dc_blocker.sv
// dc_blocker: leaky-integrator DC removal for one channel.
//   clk, reset  clock, synchronous active-high reset
//   en          update strobe (a new I/Q pair was formed)
//   x           raw signed sample
//   y           registered, DC-corrected and saturated sample
module dc_blocker
    import iq_pkg::*;
#(
    parameter int W        = IQ_W,
    parameter int DC_SHIFT = 10,
    parameter int DC_EN    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    localparam int AW = W + DC_SHIFT + 1;

    logic signed [AW-1:0] acc_r;
    logic signed [W:0]    dc_s;
    logic signed [W:0]    diff_s;
    logic signed [W-1:0]  y_next_s;

    // Estimate, difference and saturated output for the current sample.
    always_comb begin
        dc_s     = (W + 1)'(acc_r >>> DC_SHIFT);
        diff_s   = (W + 1)'(x) - dc_s;
        y_next_s = x;
        if (DC_EN != 0) begin
            y_next_s = W'(sat_w(32'(diff_s), W));
        end else begin
            y_next_s = x;
        end
    end

    // Accumulator keeps integrating the unsaturated difference; output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= '0;
            y     <= '0;
        end else if (en) begin
            y <= y_next_s;
            if (DC_EN != 0) begin
                acc_r <= acc_r + AW'(diff_s);
            end else begin
                acc_r <= '0;
            end
        end
    end

endmodule

// File: rtl/iq_deframer.sv
// iq_deframer: pairs the interleaved DIQ word stream into I/Q samples,
// removes DC per channel and flags framing violations.
//   clk, reset   word clock, synchronous active-high reset
//   IQ, iqsel    interleaved word and its I(1)/Q(0) tag
//   i_out,q_out  corrected samples, held between valid strobes
//   valid        one-cycle strobe per pair
//   frame_err    one-cycle pulse per orphan Q or double I
//   err_count    saturating count of framing violations
module iq_deframer
    import iq_pkg::*;
#(
    parameter int W        = IQ_W,
    parameter int DC_SHIFT = 10,
    parameter int DC_EN    = 1,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     IQ,
    input  logic             iqsel,
    output logic [W-1:0]     i_out,
    output logic [W-1:0]     q_out,
    output logic             valid,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count
);

    pair_state_t       state_r;
    logic [W-1:0]      i_hold_r;
    logic [W-1:0]      i_pair_r;
    logic [W-1:0]      q_pair_r;
    logic              pair_r;
    logic              valid_r;
    logic              frame_err_r;
    logic [ERR_W-1:0]  err_count_r;
    logic              err_det_s;
    logic signed [W-1:0] i_y_s;
    logic signed [W-1:0] q_y_s;

    // A violation is a Q with no held I, or an I while one is already held.
    always_comb begin
        err_det_s = 1'b0;
        case (state_r)
            WAIT_I:  err_det_s = ~iqsel;
            GOT_I:   err_det_s = iqsel;
            default: err_det_s = 1'b0;
        endcase
    end

    // Pairing FSM; a double I overwrites the held I so the newest one pairs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= WAIT_I;
            i_hold_r    <= '0;
            i_pair_r    <= '0;
            q_pair_r    <= '0;
            pair_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            pair_r      <= 1'b0;
            frame_err_r <= err_det_s;
            case (state_r)
                WAIT_I: begin
                    if (iqsel) begin
                        i_hold_r <= IQ;
                        state_r  <= GOT_I;
                    end else begin
                        state_r  <= WAIT_I;
                    end
                end
                GOT_I: begin
                    if (iqsel) begin
                        i_hold_r <= IQ;
                        state_r  <= GOT_I;
                    end else begin
                        i_pair_r <= i_hold_r;
                        q_pair_r <= IQ;
                        pair_r   <= 1'b1;
                        state_r  <= WAIT_I;
                    end
                end
                default: begin
                    state_r <= WAIT_I;
                end
            endcase
        end
    end

    // Saturating error counter, updated on the same edge the pulse is raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_r <= '0;
        end else if (err_det_s && (err_count_r != {ERR_W{1'b1}})) begin
            err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    // valid follows the pair strobe by the dc_blocker register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= pair_r;
        end
    end

    dc_blocker #(.W(W), .DC_SHIFT(DC_SHIFT), .DC_EN(DC_EN)) u_dc_i (
        .clk   (clk),
        .reset (reset),
        .en    (pair_r),
        .x     ($signed(i_pair_r)),
        .y     (i_y_s)
    );

    dc_blocker #(.W(W), .DC_SHIFT(DC_SHIFT), .DC_EN(DC_EN)) u_dc_q (
        .clk   (clk),
        .reset (reset),
        .en    (pair_r),
        .x     ($signed(q_pair_r)),
        .y     (q_y_s)
    );

    assign i_out     = i_y_s;
    assign q_out     = q_y_s;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_iq_deframer.sv
// tb_iq_deframer: directed bench for iq_deframer. Three instances share the
// input stream: dut0 pass-through, dut1 DC removal with DC_SHIFT=4, dut2
// pass-through with a 2-bit error counter.
module tb_iq_deframer;

    logic        clk;
    logic        reset;
    logic [11:0] IQ;
    logic        iqsel;

    logic [11:0] i_out0, q_out0, i_out1, q_out1, i_out2, q_out2;
    logic        valid0, valid1, valid2;
    logic        frame_err0, frame_err1, frame_err2;
    logic [7:0]  err_count0, err_count1;
    logic [1:0]  err_count2;

    int n_checks = 0;
    int n_pass   = 0;

    // monitor state (written only by the monitor process)
    int v0_cnt = 0, fe0_cnt = 0, fe2_cnt = 0, b2b_cnt = 0, overlap_cnt = 0;
    logic prev_v0 = 1'b0, prev_v1 = 1'b0;
    int q1_i[$];
    int q1_q[$];

    iq_deframer #(.W(12), .DC_SHIFT(10), .DC_EN(0), .ERR_W(8)) dut0 (
        .clk(clk), .reset(reset), .IQ(IQ), .iqsel(iqsel),
        .i_out(i_out0), .q_out(q_out0), .valid(valid0),
        .frame_err(frame_err0), .err_count(err_count0));

    iq_deframer #(.W(12), .DC_SHIFT(4), .DC_EN(1), .ERR_W(8)) dut1 (
        .clk(clk), .reset(reset), .IQ(IQ), .iqsel(iqsel),
        .i_out(i_out1), .q_out(q_out1), .valid(valid1),
        .frame_err(frame_err1), .err_count(err_count1));

    iq_deframer #(.W(12), .DC_SHIFT(10), .DC_EN(0), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .IQ(IQ), .iqsel(iqsel),
        .i_out(i_out2), .q_out(q_out2), .valid(valid2),
        .frame_err(frame_err2), .err_count(err_count2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (valid0) v0_cnt++;
        if (frame_err0) fe0_cnt++;
        if (frame_err2) fe2_cnt++;
        if ((valid0 && prev_v0) || (valid1 && prev_v1) || (valid2 && prev_v0)) b2b_cnt++;
        if ((valid0 && frame_err0) || (valid1 && frame_err1)) overlap_cnt++;
        if (valid1) begin
            q1_i.push_back(int'($signed(i_out1)));
            q1_q.push_back(int'($signed(q_out1)));
        end
        prev_v0 = valid0;
        prev_v1 = valid1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one word (reset released) just after the falling edge.
    task automatic word(input bit sel, input int v);
        @(negedge clk);
        reset = 1'b0;
        iqsel = sel;
        IQ    = 12'(v);
    endtask

    // Hold reset for the next active edge.
    task automatic rst_on();
        @(negedge clk);
        reset = 1'b1;
        iqsel = 1'b0;
        IQ    = 12'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vb, fb, base, bad;
        reset = 1'b1;
        iqsel = 1'b0;
        IQ    = 12'd0;
        rst_on();
        rst_on();
        rst_on();

        // reset state
        check_eq("rst_i_out",     int'($signed(i_out0)), 0);
        check_eq("rst_q_out",     int'($signed(q_out0)), 0);
        check_eq("rst_valid",     int'(valid0), 0);
        check_eq("rst_frame_err", int'(frame_err0), 0);
        check_eq("rst_err_count", int'(err_count0), 0);
        check_eq("rst_i_out_dc",  int'($signed(i_out1)), 0);

        // clean interleave, pass-through
        word(1'b1, 100);
        word(1'b0, -200);
        word(1'b1, 2047);
        check_eq("clean_lat_early", int'(valid0), 0);
        word(1'b0, -2048);
        check_eq("clean_valid1", int'(valid0), 1);
        check_eq("clean_i1", int'($signed(i_out0)), 100);
        check_eq("clean_q1", int'($signed(q_out0)), -200);
        word(1'b1, 0);
        check_eq("clean_gap", int'(valid0), 0);
        rst_on();
        check_eq("clean_valid2", int'(valid0), 1);
        check_eq("clean_i2", int'($signed(i_out0)), 2047);
        check_eq("clean_q2", int'($signed(q_out0)), -2048);
        check_eq("clean_errs", int'(err_count0), 0);

        // orphan Q
        rst_on();
        vb = v0_cnt;
        fb = fe0_cnt;
        word(1'b0, 5);
        word(1'b1, 7);
        check_eq("orphan_pulse", int'(frame_err0), 1);
        word(1'b0, 9);
        word(1'b1, 0);
        rst_on();
        check_eq("orphan_pulses", fe0_cnt - fb, 1);
        check_eq("orphan_err_count", int'(err_count0), 1);
        check_eq("orphan_pairs", v0_cnt - vb, 1);
        check_eq("orphan_i", int'($signed(i_out0)), 7);
        check_eq("orphan_q", int'($signed(q_out0)), 9);

        // double I
        rst_on();
        vb = v0_cnt;
        fb = fe0_cnt;
        word(1'b1, 1);
        word(1'b1, 2);
        word(1'b0, 3);
        check_eq("dbl_pulse", int'(frame_err0), 1);
        word(1'b1, 0);
        rst_on();
        check_eq("dbl_pulses", fe0_cnt - fb, 1);
        check_eq("dbl_err_count", int'(err_count0), 1);
        check_eq("dbl_pairs", v0_cnt - vb, 1);
        check_eq("dbl_i", int'($signed(i_out0)), 2);
        check_eq("dbl_q", int'($signed(q_out0)), 3);

        // reset with a held I
        rst_on();
        vb = v0_cnt;
        fb = fe0_cnt;
        word(1'b1, 50);
        rst_on();
        word(1'b0, 60);
        word(1'b1, 0);
        rst_on();
        check_eq("rmid_pairs", v0_cnt - vb, 0);
        check_eq("rmid_pulses", fe0_cnt - fb, 1);
        check_eq("rmid_err_count", int'(err_count0), 1);
        check_eq("rmid_i", int'($signed(i_out0)), 0);
        check_eq("rmid_q", int'($signed(q_out0)), 0);

        // reset on the edge after a Q: pending pair dropped
        rst_on();
        vb = v0_cnt;
        word(1'b1, 11);
        word(1'b0, 12);
        rst_on();
        rst_on();
        check_eq("rpend_pairs", v0_cnt - vb, 0);
        check_eq("rpend_valid", int'(valid0), 0);

        // counter saturation
        rst_on();
        fb = fe2_cnt;
        for (int k = 0; k < 5; k++) begin
            word(1'b0, k);
        end
        word(1'b1, 0);
        rst_on();
        check_eq("sat_pulses", fe2_cnt - fb, 5);
        check_eq("sat_err_count2", int'(err_count2), 3);
        check_eq("sat_err_count8", int'(err_count1), 5);
        check_eq("sat_valid2", int'(valid2), 0);
        check_eq("sat_i2", int'($signed(i_out2)), 0);
        check_eq("sat_q2", int'($signed(q_out2)), 0);

        // DC convergence then negative step
        rst_on();
        base = q1_i.size();
        for (int p = 0; p < 200; p++) begin
            word(1'b1, 300);
            word(1'b0, 300);
        end
        word(1'b1, -2048);
        word(1'b0, 300);
        word(1'b1, 0);
        rst_on();
        check_eq("dc_pairs", q1_i.size() - base, 201);
        if (q1_i.size() - base == 201) begin
            check_eq("dc_first_i", q1_i[base], 300);
            check_eq("dc_first_q", q1_q[base], 300);
            check_eq("dc_second_i", q1_i[base + 1], 282);
            bad = 0;
            for (int n = base + 1; n < base + 200; n++) begin
                if (q1_i[n] > q1_i[n - 1] || q1_q[n] > q1_q[n - 1] ||
                    q1_i[n] < -1 || q1_q[n] < -1) bad++;
            end
            check_eq("dc_monotonic", bad, 0);
            check_eq("dc_settle_i", int'(q1_i[base + 199] <= 1 && q1_i[base + 199] >= -1), 1);
            check_eq("dc_settle_q", int'(q1_q[base + 199] <= 1 && q1_q[base + 199] >= -1), 1);
            check_eq("dc_step_clamp", q1_i[base + 200], -2048);
        end
        check_eq("dc_step_out", int'($signed(i_out1)), -2048);
        check_eq("pass_step_out", int'($signed(i_out0)), -2048);

        // global pulse properties
        check_eq("no_back_to_back", b2b_cnt, 0);
        check_eq("no_err_with_valid", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
